// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history table controller.
//   bht_state_e : controller state (INIT sweep, RUN)
//   CNT_*       : 2-bit saturating counter constants
//   upd_entry_t : one queued branch-resolution update {index, taken}
//   sat_upd()   : saturating counter step
// The index field is sized for the largest table supported (2**BHT_IDX_W
// entries). Users zero-extend into it and truncate out of it.
package bht_pkg;

  localparam int BHT_IDX_W = 16;

  localparam logic [1:0] CNT_MAX  = 2'b11;
  localparam logic [1:0] CNT_MIN  = 2'b00;
  localparam logic [1:0] CNT_INIT = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bht_state_e;

  typedef struct packed {
    logic [BHT_IDX_W-1:0] index;
    logic                 taken;
  } upd_entry_t;

  function automatic logic [1:0] sat_upd(input logic [1:0] v, input logic taken);
    if (taken) return (v == CNT_MAX) ? CNT_MAX : v + 2'd1;
    else       return (v == CNT_MIN) ? CNT_MIN : v - 2'd1;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Q-deep update queue between execute-stage branch resolution and the table.
//   clk, rst_n          : clock, async active-low reset
//   flush               : empties the queue (wins over push/pop)
//   in_valid/in_ready   : enqueue handshake; in_ready = not full
//   in_data             : entry to enqueue
//   out_valid/out_ready : dequeue handshake; out_valid = not empty
//   out_data            : head entry
// in_ready depends only on occupancy, so a full queue refuses a push even in
// a cycle where the head is being popped.
module bht_upd_fifo
  import bht_pkg::*;
#(
  parameter int Q = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  input  upd_entry_t in_data,
  output logic       in_ready,
  output logic       out_valid,
  output upd_entry_t out_data,
  input  logic       out_ready
);

  localparam int QW = $clog2(Q);
  localparam logic [QW:0] Q_FULL = (QW+1)'(Q);

  upd_entry_t [Q-1:0] mem_q, mem_d;
  logic [QW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [QW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [QW:0]        cnt_q, cnt_d;
  logic               push, pop;

  assign in_ready  = (cnt_q != Q_FULL);
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem_q[rd_ptr_q];

  always_comb begin
    push     = in_valid && in_ready;
    pop      = out_valid && out_ready;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Pointers are QW bits wide with Q a power of two, so +1 wraps mod Q.
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + QW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + QW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (QW+1)'(1);
        2'b01:   cnt_d = cnt_q - (QW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: M x 2-bit saturating counters indexed by
// the low log2(M) PC bits, a one-cycle lookup port for fetch, and a queued
// update port for execute-stage branch resolutions.
//   clk, rst_n                   : clock, async active-low reset
//   lk_valid/lk_ready, lk_pc     : lookup request (ready only in RUN)
//   pred_valid, pred, pred_taken : prediction, one cycle after accept
//   upd_valid/upd_ready, upd_pc, upd_taken : update enqueue
//   flush_req                    : reinitialise table, drop queue and lookup
//   busy                         : high while the INIT sweep runs
// Optional: define BHT_BYPASS_EN so that a lookup hitting the entry written
// by the same-cycle dequeue returns the new value instead of the old one.
module bht_ctrl
  import bht_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 16,
  parameter int Q = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lk_valid,
  input  logic [N-1:0] lk_pc,
  output logic         lk_ready,
  output logic         pred_valid,
  output logic [1:0]   pred,
  output logic         pred_taken,
  input  logic         upd_valid,
  input  logic [N-1:0] upd_pc,
  input  logic         upd_taken,
  output logic         upd_ready,
  input  logic         flush_req,
  output logic         busy
);

  localparam int IW = $clog2(M);

  bht_state_e       state_q, state_d;
  logic [IW-1:0]    sweep_cnt_q, sweep_cnt_d;
  logic [M-1:0][1:0] table_q, table_d;
  logic             pred_valid_q, pred_valid_d;
  logic [1:0]       pred_q, pred_d;

  logic             run;
  upd_entry_t       enq_ent, deq_ent;
  logic             fifo_in_ready, fifo_out_valid, deq;
  logic [IW-1:0]    lk_idx, deq_idx;
  logic [1:0]       deq_new, rd_val;
  logic             unused_hi_bits;

  assign run        = (state_q == RUN);
  assign lk_ready   = run;
  assign busy       = !run;
  assign upd_ready  = run && fifo_in_ready;
  assign pred_valid = pred_valid_q;
  assign pred       = pred_q;
  assign pred_taken = pred_q[1];

  assign enq_ent.index = BHT_IDX_W'(upd_pc[IW-1:0]);
  assign enq_ent.taken = upd_taken;

  // Flush suppresses the dequeue write; the sweep rewrites every entry anyway.
  assign deq     = run && fifo_out_valid && !flush_req;
  assign deq_idx = deq_ent.index[IW-1:0];
  assign deq_new = sat_upd(table_q[deq_idx], deq_ent.taken);
  assign lk_idx  = lk_pc[IW-1:0];

  assign unused_hi_bits = ^{lk_pc[N-1:IW], upd_pc[N-1:IW], deq_ent.index[BHT_IDX_W-1:IW]};

  bht_upd_fifo #(.Q(Q)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush_req),
    .in_valid  (upd_valid && run),
    .in_data   (enq_ent),
    .in_ready  (fifo_in_ready),
    .out_valid (fifo_out_valid),
    .out_data  (deq_ent),
    .out_ready (run && !flush_req)
  );

  always_comb begin
`ifdef BHT_BYPASS_EN
    rd_val = (deq && (lk_idx == deq_idx)) ? deq_new : table_q[lk_idx];
`else
    rd_val = table_q[lk_idx];
`endif
  end

  always_comb begin
    state_d      = state_q;
    sweep_cnt_d  = sweep_cnt_q;
    table_d      = table_q;
    pred_valid_d = 1'b0;
    pred_d       = pred_q;
    if (flush_req) begin
      state_d     = INIT;
      sweep_cnt_d = '0;
    end else if (!run) begin
      // One entry per cycle; RUN is entered on the edge that writes M-1.
      table_d[sweep_cnt_q] = CNT_INIT;
      if (sweep_cnt_q == IW'(M-1)) begin
        state_d     = RUN;
        sweep_cnt_d = '0;
      end else begin
        sweep_cnt_d = sweep_cnt_q + IW'(1);
      end
    end else begin
      if (deq) table_d[deq_idx] = deq_new;
      if (lk_valid) begin
        pred_valid_d = 1'b1;
        pred_d       = rd_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= INIT;
      sweep_cnt_q  <= '0;
      table_q      <= '0;
      pred_valid_q <= 1'b0;
      pred_q       <= CNT_MIN;
    end else begin
      state_q      <= state_d;
      sweep_cnt_q  <= sweep_cnt_d;
      table_q      <= table_d;
      pred_valid_q <= pred_valid_d;
      pred_q       <= pred_d;
    end
  end

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl (defaults N=32, M=16, Q=4). Inputs change 1ns
// after the rising edge; outputs are sampled at the same point.
module tb_bht_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic        lk_ready;
  logic        pred_valid;
  logic [1:0]  pred;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_ready;
  logic        flush_req;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bht_ctrl #(.N(32), .M(16), .Q(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_valid   (lk_valid),
    .lk_pc      (lk_pc),
    .lk_ready   (lk_ready),
    .pred_valid (pred_valid),
    .pred       (pred),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_ready  (upd_ready),
    .flush_req  (flush_req),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [1:0] exp, input string tag);
    lk_valid = 1'b1;
    lk_pc    = pc;
    step();
    lk_valid = 1'b0;
    chk({tag, "_vld"}, 32'(pred_valid), 32'd1);
    chk(tag, 32'(pred), 32'(exp));
  endtask

  task automatic upd_one(input logic [31:0] pc, input logic tk);
    upd_valid = 1'b1;
    upd_pc    = pc;
    upd_taken = tk;
    step();
    upd_valid = 1'b0;
  endtask

  logic [1:0] exp_byp;
  logic [4:0] seq;

  initial begin
    rst_n = 1'b0; lk_valid = 1'b1; lk_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; flush_req = 1'b0;

    // Reset state
    step(); step();
    chk("rst_busy",   32'(busy),       32'd1);
    chk("rst_lkrdy",  32'(lk_ready),   32'd0);
    chk("rst_updrdy", 32'(upd_ready),  32'd0);
    chk("rst_pvld",   32'(pred_valid), 32'd0);
    chk("rst_pred",   32'(pred),       32'd0);
    rst_n = 1'b1;

    // 16-cycle INIT sweep with lookup held
    for (int i = 0; i < 16; i++) begin
      chk("init_busy",  32'(busy),       32'd1);
      chk("init_lkrdy", 32'(lk_ready),   32'd0);
      chk("init_pvld",  32'(pred_valid), 32'd0);
      step();
    end
    chk("run_busy",  32'(busy),      32'd0);
    chk("run_lkrdy", 32'(lk_ready),  32'd1);
    chk("run_updrdy", 32'(upd_ready), 32'd1);
    step();
    chk("first_pvld",  32'(pred_valid), 32'd1);
    chk("first_pred",  32'(pred),       32'd3);
    chk("first_taken", 32'(pred_taken), 32'd1);
    lk_valid = 1'b0;
    step();
    chk("idle_pvld", 32'(pred_valid), 32'd0);
    chk("idle_hold", 32'(pred),       32'd3);

    // Three not-taken at pc 0x4, read through alias pc 0x14
    upd_valid = 1'b1; upd_pc = 32'h4; upd_taken = 1'b0;
    step(); step(); step();
    upd_valid = 1'b0;
    step(); step();
    lookup(32'h14, 2'b00, "nt3_pred");
    chk("nt3_taken", 32'(pred_taken), 32'd0);
    upd_one(32'h4, 1'b0);
    step(); step();
    lookup(32'h14, 2'b00, "nt4_sat");

    // Queue latency and same-cycle read on index 8
`ifdef BHT_BYPASS_EN
    exp_byp = 2'b10;
`else
    exp_byp = 2'b11;
`endif
    upd_valid = 1'b1; upd_pc = 32'h8; upd_taken = 1'b0;
    lk_valid = 1'b1; lk_pc = 32'h8;
    step();
    upd_valid = 1'b0;
    chk("lat_pred", 32'(pred), 32'd3);
    step();
    chk("lat_byp", 32'(pred), 32'(exp_byp));
    step();
    chk("lat_after", 32'(pred), 32'd2);
    lk_valid = 1'b0;

    // Five back-to-back updates on index 6, order-sensitive: N N N T T -> 10
    seq = 5'b11000;
    for (int k = 0; k < 5; k++) begin
      chk("five_updrdy", 32'(upd_ready), 32'd1);
      upd_valid = 1'b1; upd_pc = 32'h6; upd_taken = seq[k];
      step();
    end
    upd_valid = 1'b0;
    chk("five_updrdy_end", 32'(upd_ready), 32'd1);
    step(); step();
    lookup(32'h6, 2'b10, "five_order");

    // Index 2 set to 01, then taken dequeue in same cycle as lookup
    upd_valid = 1'b1; upd_pc = 32'h2; upd_taken = 1'b0;
    step(); step();
    upd_valid = 1'b0;
    step(); step();
    lookup(32'h2, 2'b01, "idx2_pre");
`ifdef BHT_BYPASS_EN
    exp_byp = 2'b10;
`else
    exp_byp = 2'b01;
`endif
    upd_one(32'h2, 1'b1);
    lookup(32'h2, exp_byp, "idx2_byp");
    lookup(32'h2, 2'b10, "idx2_post");

    // Flush with a queued update, a new update and a lookup in the same cycle
    upd_one(32'h5, 1'b0);
    flush_req = 1'b1; lk_valid = 1'b1; lk_pc = 32'h5;
    upd_valid = 1'b1; upd_pc = 32'h5; upd_taken = 1'b0;
    step();
    flush_req = 1'b0; lk_valid = 1'b0; upd_valid = 1'b0;
    chk("fl_pvld",   32'(pred_valid), 32'd0);
    chk("fl_busy",   32'(busy),       32'd1);
    chk("fl_lkrdy",  32'(lk_ready),   32'd0);
    chk("fl_updrdy", 32'(upd_ready),  32'd0);
    for (int i = 0; i < 16; i++) begin
      chk("fl_init_busy", 32'(busy), 32'd1);
      step();
    end
    chk("fl_run_busy", 32'(busy), 32'd0);
    lk_valid = 1'b1; lk_pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      step();
      chk("fl_tbl_vld", 32'(pred_valid), 32'd1);
      chk($sformatf("fl_tbl_%0d", i), 32'(pred), 32'd3);
      lk_pc = 32'(i + 1);
    end
    lk_valid = 1'b0;
    step();
    chk("fl_end_pvld", 32'(pred_valid), 32'd0);

    // Flush during INIT at sweep_cnt 9 restarts the sweep
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    chk("fi_busy0", 32'(busy), 32'd1);
    repeat (9) step();
    chk("fi_busy9", 32'(busy), 32'd1);
    flush_req = 1'b1;
    step();
    flush_req = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("fi_restart_busy", 32'(busy), 32'd1);
      step();
    end
    chk("fi_run_busy",  32'(busy),     32'd0);
    chk("fi_run_lkrdy", 32'(lk_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
